// File: rtl/fir_mac_pipe.sv
// Pipelined signed MAC: MUL_STAGES product registers, accumulate, round/shift/saturate; last->out_valid = MUL_STAGES+2 cycles.
// Single global enable (in_ready = !out_valid || out_ready) freezes every stage while a result waits to be taken.
module fir_mac_pipe #(
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int DOUT_WIDTH = 16,
  parameter int MUL_STAGES = 2,
  parameter int SHIFT      = 15,
  parameter int ROUND      = 1,
  parameter int SAT        = 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  out_sat,
  output logic                  acc_ovf
);

  localparam int PW  = DIN0_WIDTH + DIN1_WIDTH;
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACC_WIDTH:0] ONE     = {{ACC_WIDTH{1'b0}}, 1'b1};
  localparam logic signed [ACC_WIDTH:0] RND_ADD = (ROUND != 0 && SHIFT > 0) ? (ONE <<< RSH) : '0;
  localparam logic signed [ACC_WIDTH:0] DMAX    = (ONE <<< (DOUT_WIDTH - 1)) - ONE;
  localparam logic signed [ACC_WIDTH:0] DMIN    = ~DMAX;

  logic                    en;
  logic [MUL_STAGES-1:0]   mv, mf, ml;
  logic signed [PW-1:0]    mp [MUL_STAGES];
  logic signed [PW-1:0]    prod;
  logic signed [ACC_WIDTH-1:0] acc, prod_ext, acc_sum;
  logic                    add_ovf;
  logic                    acc_emit;
  logic signed [ACC_WIDTH:0] rnd, shf;
  logic [DOUT_WIDTH-1:0]   res;
  logic                    res_sat;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  assign prod     = PW'($signed(din0)) * PW'($signed(din1));
  assign prod_ext = ACC_WIDTH'(mp[MUL_STAGES-1]);
  assign acc_sum  = acc + prod_ext;
  // Two's-complement overflow: same-sign operands giving a different-sign sum.
  assign add_ovf  = (acc[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                    (acc_sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);

  // Guard bit keeps the rounding add from wrapping at the accumulator's positive limit.
  assign rnd = $signed({acc[ACC_WIDTH-1], acc}) + RND_ADD;
  assign shf = rnd >>> SHIFT;

  always_comb begin
    res     = shf[DOUT_WIDTH-1:0];
    res_sat = 1'b0;
    if (SAT != 0) begin
      if (shf > DMAX) begin
        res     = DMAX[DOUT_WIDTH-1:0];
        res_sat = 1'b1;
      end else if (shf < DMIN) begin
        res     = DMIN[DOUT_WIDTH-1:0];
        res_sat = 1'b1;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      mv        <= '0;
      mf        <= '0;
      ml        <= '0;
      for (int i = 0; i < MUL_STAGES; i++) mp[i] <= '0;
      acc       <= '0;
      acc_emit  <= 1'b0;
      acc_ovf   <= 1'b0;
      dout      <= '0;
      out_sat   <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      mv[0] <= in_valid;
      mf[0] <= in_first;
      ml[0] <= in_last;
      mp[0] <= prod;
      for (int i = 1; i < MUL_STAGES; i++) begin
        mv[i] <= mv[i-1];
        mf[i] <= mf[i-1];
        ml[i] <= ml[i-1];
        mp[i] <= mp[i-1];
      end

      if (mv[MUL_STAGES-1]) begin
        if (mf[MUL_STAGES-1]) begin
          acc <= prod_ext;
        end else begin
          acc <= acc_sum;
          if (add_ovf) acc_ovf <= 1'b1;
        end
      end
      acc_emit <= mv[MUL_STAGES-1] && ml[MUL_STAGES-1];

      // acc still holds the finished sum here even if the next frame updates it this edge.
      if (acc_emit) begin
        dout      <= res;
        out_sat   <= res_sat;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fir_mac_pipe.md
Name: fir_mac_pipe

Overview:
- Parametrised, pipelined signed multiply-accumulate unit for the FIR datapath.
- Supersedes the single-cycle combinational coefficient×sample multiplier. Adds configurable multiplier pipeline depth, a wide accumulator with first/last framing, and rounding, shift and saturation to the output width.
- Output uses a valid/ready handshake with full-pipeline backpressure.
- Sits between the tap/coefficient sequencer and the output sample FIFO.

Parameters:
- DIN0_WIDTH, 16, sample width (signed).
- DIN1_WIDTH, 16, coefficient width (signed).
- ACC_WIDTH, 40, accumulator width. Must be ≥ DIN0_WIDTH+DIN1_WIDTH.
- DOUT_WIDTH, 16, result width (signed).
- MUL_STAGES, 2, number of product register stages. Legal range 1..4.
- SHIFT, 15, arithmetic right shift applied to the accumulator at output. Legal range 0..ACC_WIDTH-DOUT_WIDTH.
- ROUND, 1. 1 = add 2^(SHIFT-1) before the shift (round half up). 0 = truncate. Ignored when SHIFT=0.
- SAT, 1. 1 = clamp to the DOUT range. 0 = keep the low DOUT_WIDTH bits (wrap).

Ports:
- ap_clk  in  1  clock; all logic rises on this edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  sample/coefficient pair present.
- in_ready  out  1  pipeline can accept a pair this cycle.
- in_first  in  1  pair starts a new accumulation.
- in_last  in  1  pair ends the accumulation; result is emitted.
- din0  in  DIN0_WIDTH  signed sample.
- din1  in  DIN1_WIDTH  signed coefficient.
- out_valid  out  1  result held on dout.
- out_ready  in  1  downstream accepts the result.
- dout  out  DOUT_WIDTH  signed result.
- out_sat  out  1  this result was clamped. Qualified by out_valid.
- acc_ovf  out  1  sticky flag: accumulator two's-complement overflow since reset.

Behaviour:
- Reset (ap_rst_n=0, asynchronous):
  - All stage valid bits, accumulator, dout, out_valid, out_sat and acc_ovf clear to 0.
  - in_ready reads 1 after reset.
  - Any partial accumulation in flight is discarded.
- Handshake:
  - en = in_ready = !out_valid || out_ready. This is a single global enable; the whole pipeline advances only when en=1.
  - A pair is accepted when in_valid && in_ready. in_first, in_last and the data travel with the pair's valid bit.
  - When en=0, every stage register holds. dout, out_sat and out_valid are stable until accepted.
- Multiply stages 1..MUL_STAGES:
  - The full-precision signed product (DIN0_WIDTH+DIN1_WIDTH bits) is registered at stage 1 and carried through the remaining stages unchanged.
  - Bubbles (valid=0) propagate without affecting the accumulator.
- Accumulate stage, on a valid pair:
  - first=1: acc <= sign-extended product.
  - first=0: acc <= acc + product.
  - Overflow in the add sets acc_ovf (sticky); acc wraps.
  - A pair without first after a completed last continues accumulating on the held acc value. The sequencer must assert first.
  - first=1 and last=1 on the same pair emits a single-product result.
- Output stage (loaded when the accumulate stage holds a valid last and en=1):
  - r = acc_new + (ROUND && SHIFT>0 ? 2^(SHIFT-1) : 0), computed with one guard bit.
  - s = r >>> SHIFT (arithmetic shift).
  - SAT=1: dout = clamp(s, -2^(DOUT-1), 2^(DOUT-1)-1), and out_sat=1 iff a clamp occurred.
  - SAT=0: dout = s[DOUT-1:0], out_sat=0.
  - out_valid <= 1.
- out_valid clears when out_ready=1 and no new result is loaded. Back-to-back results load with out_valid staying 1.
- Latency: acceptance of the last pair → out_valid is MUL_STAGES+2 cycles without stall. Default configuration = 4 cycles.
- Throughput: one pair per cycle while out_ready=1.

Test Plan:
- Default parameters, one pair with first=last=1, din0=0x4000, din1=0x4000 → out_valid rises exactly 4 cycles later with dout=0x2000, out_sat=0.
- Four pairs 0x7FFF×0x7FFF (first on pair 1, last on pair 4) → acc=0xFFFC0004. The shifted value is 0x1FFF8, so dout=0x7FFF, out_sat=1, acc_ovf=0.
- Single pair 0x8000×0x7FFF with ROUND=1 → dout=0x8001, out_sat=0. With SAT=1 and a single pair 0x8000×0x8000 → dout=0x7FFF, out_sat=1.
- Result pending with out_ready held low 3 cycles → in_ready=0, no pairs accepted, and dout/out_valid stable. Release → result consumed and pipeline resumes with no lost or duplicated pairs.
- Assert ap_rst_n low after 2 of 4 accepted pairs → out_valid=0 and acc_ovf=0 immediately. A following first/last pair 0x0100×0x0100 gives dout=0x0002 with no residue.
- Stream of 8 first=last pairs back-to-back with out_ready=1 → 8 consecutive out_valid cycles, each dout matching its own product, one result per cycle.
